// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage MIPS pipeline.
//
// Sits between the ID/EX register (DX_*) and the memory stage, producing the
// registered XM_* bundle. Contains the ALU, operand-2 select, jal return
// address passthrough and a sequential 32-step signed multiply/divide unit
// that owns HI/LO.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   DX_* controls       MemtoReg/RegWrite/MemRead/MemWrite/jal, ALUSrc, ALUctr
//   DX_A, DX_B, DX_imm  operands (forwarded rs/rt, extended immediate)
//   DX_shamt, DX_RD, DX_RT, DX_jaladdr
//   ex_stall            combinational; upstream holds DX_* and PC while high
//   XM_* / ALUout       registered results for the memory stage
module execute_stage #(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DX_MemtoReg,
  input  logic        DX_RegWrite,
  input  logic        DX_MemRead,
  input  logic        DX_MemWrite,
  input  logic        DX_jal,
  input  logic        DX_ALUSrc,
  input  logic [3:0]  DX_ALUctr,
  input  logic [31:0] DX_A,
  input  logic [31:0] DX_B,
  input  logic [31:0] DX_imm,
  input  logic [4:0]  DX_shamt,
  input  logic [4:0]  DX_RD,
  input  logic [4:0]  DX_RT,
  input  logic [31:0] DX_jaladdr,
  output logic        ex_stall,
  output logic        XM_MemtoReg,
  output logic        XM_RegWrite,
  output logic        XM_MemRead,
  output logic        XM_MemWrite,
  output logic        XM_jal,
  output logic [31:0] ALUout,
  output logic [31:0] XM_MD,
  output logic [4:0]  XM_RD,
  output logic [31:0] XM_swaddr,
  output logic [31:0] XM_jaladdr
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(MD_ITER);

  localparam logic [3:0] OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4,  OP_NOR  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8,  OP_XOR  = 4'd9,  OP_LUI  = 4'd10, OP_MULT = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_SLTU = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  md_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic                      md_div, sign_a, sign_b, div_zero;
  logic [DATA_W-1:0]         a_raw;
  logic [DATA_W-1:0]         mcand;     // multiplicand magnitude, or divisor magnitude
  logic [2*DATA_W-1:0]       acc;       // {partial product | remainder, multiplier | quotient}
  logic [DATA_W-1:0]         hi, lo;

  logic                      md_req, bubble;
  logic [DATA_W-1:0]         op2, alu_res;
  logic [DATA_W:0]           mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0]       acc_next, prod;
  logic [DATA_W-1:0]         hi_res, lo_res;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
    return DATA_W'(0) - v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v);
    return (2*DATA_W)'(0) - v;
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg32(v) : v;
  endfunction

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [3:0]        ctr,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b2,
    input logic [DATA_W-1:0] b,
    input logic [4:0]        sh,
    input logic [DATA_W-1:0] hi_v,
    input logic [DATA_W-1:0] lo_v
  );
    logic signed [DATA_W-1:0] sa, sb2, sb;
    logic [DATA_W-1:0]        r;
    sa  = a;
    sb2 = b2;
    sb  = b;
    r   = '0;
    case (ctr)
      OP_AND:  r = a & b2;
      OP_OR:   r = a | b2;
      OP_ADD:  r = a + b2;
      OP_SUB:  r = a - b2;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, (sa < sb2)};
      OP_NOR:  r = ~(a | b2);
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = sb >>> sh;
      OP_XOR:  r = a ^ b2;
      OP_LUI:  r = {b2[15:0], 16'h0000};
      OP_MFHI: r = hi_v;
      OP_MFLO: r = lo_v;
      OP_SLTU: r = {{(DATA_W-1){1'b0}}, (a < b2)};
      default: r = '0;  // MULT/DIV never reach XM
    endcase
    return r;
  endfunction

  assign md_req   = (DX_ALUctr == OP_MULT) || (DX_ALUctr == OP_DIV);
  assign ex_stall = ((state == IDLE) && md_req) || (state == RUN);
  assign bubble   = ex_stall || (state == DONE);
  assign op2      = DX_ALUSrc ? DX_imm : DX_B;
  assign alu_res  = alu_f(DX_ALUctr, DX_A, op2, DX_B, DX_shamt, hi, lo);

  // One iteration of shift-add multiply or restoring shift-subtract divide.
  // The remainder stays below the divisor magnitude (<= 2^31), so the shifted
  // remainder fits in 32 bits and div_diff[32] is a true borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
    div_shift = acc[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, mcand};
    acc_next  = acc;
    if (!md_div)
      acc_next = {mul_sum, acc[DATA_W-1:1]};
    else if (!div_diff[DATA_W])
      acc_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else
      acc_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
  end

  // Sign correction of the magnitude result; divide by zero bypasses it.
  always_comb begin
    prod   = (sign_a ^ sign_b) ? neg64(acc) : acc;
    hi_res = prod[2*DATA_W-1:DATA_W];
    lo_res = prod[DATA_W-1:0];
    if (md_div) begin
      if (div_zero) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = sign_a ? neg32(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
        lo_res = (sign_a ^ sign_b) ? neg32(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
      end
    end
  end

  // ---- multiply/divide FSM: IDLE latch -> RUN x MD_ITER -> DONE writes HI/LO ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      md_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      mcand    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_req) begin
            state    <= RUN;
            cnt      <= '0;
            md_div   <= (DX_ALUctr == OP_DIV);
            sign_a   <= DX_A[DATA_W-1];
            sign_b   <= DX_B[DATA_W-1];
            div_zero <= (DX_B == '0);
            a_raw    <= DX_A;
            if (DX_ALUctr == OP_DIV) begin
              mcand <= mag(DX_B);
              acc   <= {{DATA_W{1'b0}}, mag(DX_A)};
            end else begin
              mcand <= mag(DX_A);
              acc   <= {{DATA_W{1'b0}}, mag(DX_B)};
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MD_ITER - 1))
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          hi    <= hi_res;
          lo    <= lo_res;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- EX/MEM register: captures a bubble while the MD unit is occupied ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      XM_MemtoReg <= 1'b0;
      XM_RegWrite <= 1'b0;
      XM_MemRead  <= 1'b0;
      XM_MemWrite <= 1'b0;
      XM_jal      <= 1'b0;
      ALUout      <= '0;
      XM_MD       <= '0;
      XM_RD       <= '0;
      XM_swaddr   <= '0;
      XM_jaladdr  <= '0;
    end else begin
      XM_MemtoReg <= DX_MemtoReg;
      XM_RegWrite <= DX_RegWrite;
      XM_MemRead  <= DX_MemRead;
      XM_MemWrite <= DX_MemWrite;
      XM_jal      <= DX_jal;
      ALUout      <= DX_jal ? DX_jaladdr : alu_res;
      XM_MD       <= DX_B;
      XM_RD       <= DX_jal ? 5'd31 : DX_RD;
      XM_swaddr   <= {27'b0, DX_RT};
      XM_jaladdr  <= DX_jal ? DX_jaladdr : '0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: table-driven single-cycle vectors, hand-written
// multiply/divide and reset sequences, then randomized traffic against a
// reference model built from plain signed arithmetic.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_jal, DX_ALUSrc;
  logic [3:0]  DX_ALUctr;
  logic [31:0] DX_A, DX_B, DX_imm, DX_jaladdr;
  logic [4:0]  DX_shamt, DX_RD, DX_RT;
  logic        ex_stall;
  logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_jal;
  logic [31:0] ALUout, XM_MD, XM_swaddr, XM_jaladdr;
  logic [4:0]  XM_RD;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  execute_stage #(.MD_ITER(32)) dut (
    .clk(clk), .rst(rst),
    .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite), .DX_MemRead(DX_MemRead),
    .DX_MemWrite(DX_MemWrite), .DX_jal(DX_jal), .DX_ALUSrc(DX_ALUSrc),
    .DX_ALUctr(DX_ALUctr), .DX_A(DX_A), .DX_B(DX_B), .DX_imm(DX_imm),
    .DX_shamt(DX_shamt), .DX_RD(DX_RD), .DX_RT(DX_RT), .DX_jaladdr(DX_jaladdr),
    .ex_stall(ex_stall),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead),
    .XM_MemWrite(XM_MemWrite), .XM_jal(XM_jal), .ALUout(ALUout), .XM_MD(XM_MD),
    .XM_RD(XM_RD), .XM_swaddr(XM_swaddr), .XM_jaladdr(XM_jaladdr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctr;
    logic        src;
    logic [31:0] a, b, imm;
    logic [4:0]  sh, rd, rt;
    logic        rw, mw, jal;
    logic [31:0] ja;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_dx(input logic [3:0] ctr, input logic src, input logic [31:0] a, b, imm,
                        input logic [4:0] sh, rd, rt, input logic rw, mw, jal,
                        input logic [31:0] ja);
    DX_ALUctr = ctr;  DX_ALUSrc = src; DX_A = a; DX_B = b; DX_imm = imm;
    DX_shamt = sh;    DX_RD = rd;      DX_RT = rt;
    DX_RegWrite = rw; DX_MemWrite = mw; DX_jal = jal; DX_jaladdr = ja;
    DX_MemRead = 1'b0; DX_MemtoReg = 1'b0;
  endtask

  // Reference ALU from the operation table, plain arithmetic on int.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, b, imm,
                                          input logic src, input logic [4:0] sh,
                                          input logic [31:0] h, l);
    logic [31:0] o2;
    int sa, so2, sb;
    o2 = src ? imm : b;
    sa = a; so2 = o2; sb = b;
    case (c)
      4'd0:  return a & o2;
      4'd1:  return a | o2;
      4'd2:  return a + o2;
      4'd3:  return a - o2;
      4'd4:  return (sa < so2) ? 32'd1 : 32'd0;
      4'd5:  return ~(a | o2);
      4'd6:  return b << sh;
      4'd7:  return b >> sh;
      4'd8:  return sb >>> sh;
      4'd9:  return a ^ o2;
      4'd10: return {o2[15:0], 16'h0};
      4'd13: return h;
      4'd14: return l;
      4'd15: return (a < o2) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Issue a MULT/DIV, measure stall length, check bubbles, update HI/LO model.
  task automatic run_md(input logic [3:0] ctr, input logic [31:0] a, b);
    int n;
    logic bub_ok;
    int sa, sb;
    longint p;
    set_dx(ctr, 1'b0, a, b, 32'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    n = 0;
    bub_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ex_stall) break;
      n++;
      if (n > 1 && (ALUout !== 32'd0 || XM_RegWrite !== 1'b0 || XM_RD !== 5'd0)) bub_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("md_stall_cycles", n, 33);
    chk("md_bubble_during_stall", {31'd0, bub_ok}, 32'd1);
    @(posedge clk); #1;
    chk("md_done_bubble", {26'd0, XM_RegWrite, XM_RD}, 32'd0);
    sa = a; sb = b;
    if (ctr == 4'd11) begin
      p = longint'(sa) * longint'(sb);
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (sb == 0) begin
      m_hi = a;
      m_lo = 32'hFFFFFFFF;
    end else begin
      m_lo = sa / sb;
      m_hi = sa % sb;
    end
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, exp_lo);
    set_dx(4'd13, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("mfhi", ALUout, exp_hi);
    set_dx(4'd14, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("mflo", ALUout, exp_lo);
  endtask

  initial begin
    logic [3:0]  c;
    logic        src, jal, rw, mw;
    logic [31:0] a, b, imm, ja, exp;
    logic [4:0]  sh, rd, rt;

    //            ctr    src   a             b             imm           sh     rd     rt      rw    mw    jal   ja        exp_alu
    vecs[0]  = '{4'd2,  1'b1, 32'd5,        32'd0,        32'hFFFFFFFD, 5'd0,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'd2};
    vecs[1]  = '{4'd4,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'd1};
    vecs[2]  = '{4'd15, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'd0};
    vecs[3]  = '{4'd3,  1'b0, 32'd3,        32'd5,        32'd0,        5'd0,  5'd4,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'hFFFFFFFE};
    vecs[4]  = '{4'd0,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h0000F000};
    vecs[5]  = '{4'd1,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h0000FFF0};
    vecs[6]  = '{4'd5,  1'b0, 32'd0,        32'd0,        32'd0,        5'd0,  5'd6,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'hFFFFFFFF};
    vecs[7]  = '{4'd6,  1'b0, 32'd0,        32'd1,        32'd0,        5'd31, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h80000000};
    vecs[8]  = '{4'd7,  1'b0, 32'd0,        32'h80000000, 32'd0,        5'd4,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h08000000};
    vecs[9]  = '{4'd8,  1'b0, 32'd0,        32'h80000000, 32'd0,        5'd4,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'hF8000000};
    vecs[10] = '{4'd9,  1'b0, 32'h0000FF00, 32'h00000FF0, 32'd0,        5'd0,  5'd10, 5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h0000F0F0};
    vecs[11] = '{4'd10, 1'b1, 32'd0,        32'd0,        32'h00001234, 5'd0,  5'd11, 5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h12340000};
    vecs[12] = '{4'd2,  1'b0, 32'd1,        32'd2,        32'd0,        5'd0,  5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 32'h40,   32'h40};
    vecs[13] = '{4'd2,  1'b1, 32'h100,      32'hAB,       32'd4,        5'd0,  5'd0,  5'd12, 1'b0, 1'b1, 1'b0, 32'd0,    32'h104};
    vecs[14] = '{4'd2,  1'b0, 32'h7FFFFFFF, 32'd1,        32'd0,        5'd0,  5'd13, 5'd0,  1'b1, 1'b0, 1'b0, 32'd0,    32'h80000000};

    // Reset state, checked before any clock edge.
    rst = 1'b1;
    set_dx(4'd2, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    chk("rst_aluout", ALUout, 32'd0);
    chk("rst_rd", {27'd0, XM_RD}, 32'd0);
    chk("rst_swaddr", XM_swaddr, 32'd0);
    chk("rst_ctrl", {27'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_jal}, 32'd0);
    chk("rst_jaladdr", XM_jaladdr, 32'd0);
    chk("rst_stall", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single-cycle operations.
    for (int i = 0; i < 15; i++) begin
      set_dx(vecs[i].ctr, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].sh,
             vecs[i].rd, vecs[i].rt, vecs[i].rw, vecs[i].mw, vecs[i].jal, vecs[i].ja);
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, ex_stall}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_aluout", i), ALUout, vecs[i].exp_alu);
      chk($sformatf("vec%0d_rd", i), {27'd0, XM_RD}, {27'd0, vecs[i].jal ? 5'd31 : vecs[i].rd});
      chk($sformatf("vec%0d_regwrite", i), {31'd0, XM_RegWrite}, {31'd0, vecs[i].rw});
      chk($sformatf("vec%0d_memwrite", i), {31'd0, XM_MemWrite}, {31'd0, vecs[i].mw});
      chk($sformatf("vec%0d_jal", i), {31'd0, XM_jal}, {31'd0, vecs[i].jal});
      chk($sformatf("vec%0d_jaladdr", i), XM_jaladdr, vecs[i].jal ? vecs[i].ja : 32'd0);
      chk($sformatf("vec%0d_swaddr", i), XM_swaddr, {27'd0, vecs[i].rt});
      chk($sformatf("vec%0d_md", i), XM_MD, vecs[i].b);
    end

    // Multiply/divide corner cases with fixed expected values.
    run_md(4'd11, 32'hFFFFFFFD, 32'd100000);
    read_hilo(32'hFFFFFFFF, 32'hFFFB6C20);
    run_md(4'd12, 32'hFFFFFFF9, 32'd2);
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md(4'd12, 32'd9, 32'd0);
    read_hilo(32'd9, 32'hFFFFFFFF);

    // Back-to-back MULT: second one is picked up right after DONE.
    run_md(4'd11, 32'd7, 32'd6);
    run_md(4'd11, 32'h80000000, 32'd2);
    read_hilo(32'hFFFFFFFF, 32'h00000000);

    // Asynchronous reset at RUN iteration 10.
    set_dx(4'd11, 1'b0, 32'hFFFFFFFD, 32'd100000, 32'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_stall", {31'd0, ex_stall}, 32'd1);
    DX_ALUctr = 4'd2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_stall", {31'd0, ex_stall}, 32'd0);
    chk("midrun_rst_aluout", ALUout, 32'd0);
    chk("midrun_rst_rd", {27'd0, XM_RD}, 32'd0);
    chk("midrun_rst_swaddr", XM_swaddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    read_hilo(32'd0, 32'd0);
    run_md(4'd11, 32'hFFFFFFFD, 32'd100000);
    read_hilo(32'hFFFFFFFF, 32'hFFFB6C20);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      c   = 4'($urandom_range(15));
      a   = $urandom;
      b   = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom;
      if ($urandom_range(15) == 0) b = 32'd0;
      if (c == 4'd11 || c == 4'd12) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
        run_md(c, a, b);
        read_hilo(m_hi, m_lo);
      end else begin
        src = 1'($urandom_range(1));
        imm = $urandom;
        sh  = 5'($urandom_range(31));
        rd  = 5'($urandom_range(31));
        rt  = 5'($urandom_range(31));
        rw  = 1'($urandom_range(1));
        mw  = 1'($urandom_range(1));
        jal = ($urandom_range(7) == 0);
        ja  = $urandom;
        set_dx(c, src, a, b, imm, sh, rd, rt, rw, mw, jal, ja);
        exp = jal ? ja : ref_alu(c, a, b, imm, src, sh, m_hi, m_lo);
        @(posedge clk); #1;
        chk("rand_aluout", ALUout, exp);
        chk("rand_rd", {27'd0, XM_RD}, {27'd0, jal ? 5'd31 : rd});
        chk("rand_jaladdr", XM_jaladdr, jal ? ja : 32'd0);
        chk("rand_ctrl", {30'd0, XM_RegWrite, XM_MemWrite}, {30'd0, rw, mw});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
